// File: rtl/cpu_boot_ctrl.sv
// Boot/run sequencer for the pipelined RISC-V core: streams a program into imem,
// runs the core for a fixed cycle budget, then streams a dmem window back out.
module cpu_boot_ctrl #(
  parameter int IMEM_WORDS = 512,
  parameter int DMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [9:0]  prog_len,
  input  logic [31:0] run_cycles,
  input  logic [10:0] dump_len,
  input  logic        ld_valid,
  input  logic [31:0] ld_data,
  output logic        ld_ready,
  output logic        cpu_arst_n,
  output logic        cpu_enable,
  output logic [63:0] imem_addr,
  output logic        imem_wen,
  output logic [31:0] imem_wdata,
  output logic [63:0] dmem_addr,
  output logic        dmem_ren,
  input  logic [63:0] dmem_rdata,
  output logic        dump_valid,
  output logic [63:0] dump_data,
  input  logic        dump_ready,
  output logic        busy,
  output logic        done,
  output logic [31:0] cycle_count
);
  // The core's wen_ext_2 and ren_ext are tied low at integration; this block never drives them.
  localparam logic [9:0]  PLEN_MAX = 10'(IMEM_WORDS);
  localparam logic [10:0] DLEN_MAX = 11'(DMEM_WORDS);

  typedef enum logic [2:0] {
    IDLE, LOAD, RUN, DUMP_RD, DUMP_WAIT, DUMP_OUT, DONE
  } state_t;

  state_t      state_q, state_d;
  logic [9:0]  plen_q, plen_d, widx_q, widx_d;
  logic [10:0] dlen_q, dlen_d, j_q, j_d;
  logic [31:0] run_left_q, run_left_d, cycle_d;
  logic        ld_ready_d, arst_n_d, en_d, imem_wen_d, dmem_ren_d, dump_valid_d, busy_d, done_d;
  logic [63:0] imem_addr_d, dmem_addr_d, dump_data_d;
  logic [31:0] imem_wdata_d;

  always_comb begin
    state_d      = state_q;
    plen_d       = plen_q;
    dlen_d       = dlen_q;
    widx_d       = widx_q;
    j_d          = j_q;
    run_left_d   = run_left_q;
    cycle_d      = (cpu_enable && cycle_count != '1) ? cycle_count + 32'd1 : cycle_count;
    en_d         = 1'b0;
    imem_wen_d   = 1'b0;
    imem_addr_d  = imem_addr;
    imem_wdata_d = imem_wdata;
    dmem_addr_d  = dmem_addr;
    dump_data_d  = dump_data;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = LOAD;
          plen_d     = (prog_len > PLEN_MAX) ? PLEN_MAX : prog_len;
          dlen_d     = (dump_len > DLEN_MAX) ? DLEN_MAX : dump_len;
          run_left_d = run_cycles;
          widx_d     = '0;
          j_d        = '0;
          cycle_d    = '0;
        end
      end
      LOAD: begin
        if (ld_valid && ld_ready) begin
          imem_wen_d   = 1'b1;
          imem_addr_d  = {52'b0, widx_q, 2'b00};
          imem_wdata_d = ld_data;
          widx_d       = widx_q + 10'd1;
        end
        // Enable rises with reset release, in the same cycle the last word lands.
        if (widx_d == plen_q) begin
          state_d = RUN;
          en_d    = (run_left_q != '0);
        end
      end
      RUN: begin
        run_left_d = run_left_q - {31'b0, cpu_enable};
        if (run_left_d == '0) state_d = (dlen_q == '0) ? DONE : DUMP_RD;
        else                  en_d    = 1'b1;
      end
      DUMP_RD:   state_d = DUMP_WAIT;
      DUMP_WAIT: begin
        dump_data_d = dmem_rdata;
        state_d     = DUMP_OUT;
      end
      DUMP_OUT: begin
        if (dump_ready) begin
          j_d     = j_q + 11'd1;
          state_d = (j_d == dlen_q) ? DONE : DUMP_RD;
        end
      end
      default: state_d = IDLE;
    endcase
    // Every output is a register loaded from the next-state view.
    dmem_ren_d = (state_d == DUMP_RD);
    if (dmem_ren_d) dmem_addr_d = {50'b0, j_d, 3'b000};
    ld_ready_d   = (state_d == LOAD) && (widx_d < plen_d);
    dump_valid_d = (state_d == DUMP_OUT);
    busy_d       = state_d inside {LOAD, RUN, DUMP_RD, DUMP_WAIT, DUMP_OUT};
    done_d       = (state_d == DONE);
    arst_n_d     = state_d inside {RUN, DUMP_RD, DUMP_WAIT, DUMP_OUT, DONE};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      plen_q      <= '0;
      dlen_q      <= '0;
      widx_q      <= '0;
      j_q         <= '0;
      run_left_q  <= '0;
      ld_ready    <= 1'b0;
      cpu_arst_n  <= 1'b0;
      cpu_enable  <= 1'b0;
      imem_addr   <= '0;
      imem_wen    <= 1'b0;
      imem_wdata  <= '0;
      dmem_addr   <= '0;
      dmem_ren    <= 1'b0;
      dump_valid  <= 1'b0;
      dump_data   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cycle_count <= '0;
    end else begin
      state_q     <= state_d;
      plen_q      <= plen_d;
      dlen_q      <= dlen_d;
      widx_q      <= widx_d;
      j_q         <= j_d;
      run_left_q  <= run_left_d;
      ld_ready    <= ld_ready_d;
      cpu_arst_n  <= arst_n_d;
      cpu_enable  <= en_d;
      imem_addr   <= imem_addr_d;
      imem_wen    <= imem_wen_d;
      imem_wdata  <= imem_wdata_d;
      dmem_addr   <= dmem_addr_d;
      dmem_ren    <= dmem_ren_d;
      dump_valid  <= dump_valid_d;
      dump_data   <= dump_data_d;
      busy        <= busy_d;
      done        <= done_d;
      cycle_count <= cycle_d;
    end
  end
endmodule
